// File: rtl/counter_pkg.sv
// Shared constants for the counter family: direction encoding and boundary mode.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;

    localparam bit   MODE_WRAP = 1'b0;
    localparam bit   MODE_SAT  = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_next_val.sv
// Combinational next-count logic: step one position in the requested direction,
// wrapping or holding at the ends of 0..MAX_VAL. The compare happens before the
// add/subtract, so the arithmetic never needs more than WIDTH bits.
module counter_next_val
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] cur,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             at_bnd
);

    // At a boundary the step either holds (saturate) or jumps to the other end.
    always_comb begin
        at_bnd = (up == DIR_UP) ? (cur == MAX_VAL) : (cur == '0);
        if (at_bnd) begin
            if (SATURATE == MODE_SAT) nxt = cur;
            else                      nxt = (up == DIR_UP) ? '0 : MAX_VAL;
        end else begin
            nxt = (up == DIR_UP) ? cur + WIDTH'(1) : cur - WIDTH'(1);
        end
    end

endmodule : counter_next_val

// File: rtl/updown_mod_counter.sv
// Up/down counter over 0..MAX_VAL with parallel load, count enable,
// wrap-or-saturate boundary handling, a combinational terminal-count flag and a
// registered one-cycle boundary pulse.
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             bnd
);

    logic [WIDTH-1:0] step_val;
    logic             at_bnd;
    logic [WIDTH-1:0] load_clamped;

    counter_next_val #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_next (
        .cur    (out),
        .up     (up),
        .nxt    (step_val),
        .at_bnd (at_bnd)
    );

    // Out-of-range loads clamp to the terminal count so the range invariant holds.
    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // tc marks the cycle whose edge performs the wrap or saturation.
    assign tc = en & at_bnd;

    // Priority: reset, load, count. bnd only reflects an enabled boundary step.
    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
            bnd <= 1'b0;
        end else if (load) begin
            out <= load_clamped;
            bnd <= 1'b0;
        end else if (en) begin
            out <= step_val;
            bnd <= tc;
        end else begin
            bnd <= 1'b0;
        end
    end

endmodule : updown_mod_counter

// File: doc/updown_mod_counter.md
# updown_mod_counter

Parametrised synchronous up/down counter with programmable modulus, parallel load, count enable, wrap-or-saturate mode and boundary flags. It is the general-purpose successor to the team's fixed 3-bit free-running counter. It serves as the standard counting primitive for timers, address generators and event counters elsewhere in the design.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥ 1).
- MAX_VAL, 2**WIDTH-1, terminal count; legal count range is 0..MAX_VAL. MAX_VAL must be ≤ 2**WIDTH-1.
- SATURATE, 0, boundary mode: 0 wraps around, 1 holds at the boundary.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 counts up, 0 counts down.
- load  input  1  parallel load strobe.
- load_val  input  WIDTH  value to load.
- out  output  WIDTH  registered count value.
- tc  output  1  combinational terminal-count flag.
- bnd  output  1  registered boundary-event pulse.

## Operation
- Reset values: out = 0, bnd = 0. tc follows its equation from out, so tc = en & ~up after reset.
- Priority per cycle: reset, then load, then en. With none of these asserted, out holds.
- Load: out ← min(load_val, MAX_VAL). Loading never sets bnd.
- Count up with en=1: if out < MAX_VAL, out ← out+1. If out == MAX_VAL, out ← 0 when SATURATE=0, or stays at MAX_VAL when SATURATE=1.
- Count down with en=1: if out > 0, out ← out−1. If out == 0, out ← MAX_VAL when SATURATE=0, or stays at 0 when SATURATE=1.
- tc = en & ((up & out==MAX_VAL) | (~up & out==0)). It marks the cycle whose clock edge performs the wrap or saturation.
- bnd is registered. It is 1 in the cycle after any edge where en=1, load=0, reset=0 and tc=1. It is 0 otherwise, so it is a one-cycle pulse per boundary event. Saturation attempts while held still pulse bnd every enabled cycle.
- Arithmetic is unsigned, modulo MAX_VAL+1. No intermediate value exceeds WIDTH bits, because the compare happens before the increment.
- The direction input may change on any cycle. The new direction takes effect on the next edge with no penalty.
- The counter never leaves 0..MAX_VAL after reset.

## Timing
- Latency: one clock from en, load or reset to the new out value.
- Latency: one clock from the boundary edge to bnd.
- tc is combinational from en, up and out. It has no register stage and no path from load_val.
- Reset asserted mid-count: the next edge gives out = 0 and bnd = 0, regardless of en, load and up.
- Simultaneous load and en: load wins, and bnd = 0 on the following cycle.

## Structure
- Shared package counter_pkg holds DIR_UP = 1'b1, DIR_DOWN = 1'b0, MODE_WRAP = 0 and MODE_SAT = 1. Other counters in the codebase reuse these constants.
- One sub-module, counter_next_val: purely combinational. It takes out, up and SATURATE and returns the next value and the boundary flag. The top level holds only the registers and the priority mux.

## Test plan
Configuration: WIDTH=3, MAX_VAL=5 unless stated otherwise.
- Reset then en=1, up=1 for 8 cycles: out = 0,1,2,3,4,5,0,1,2; tc=1 only while out=5; bnd=1 exactly in the cycle where out first reads 0.
- Load load_val=2, then en=1, up=0: out = 2,1,0,5,4; bnd pulses once, in the cycle after the 0→5 transition edge.
- SATURATE=1, up=1 from 4: out = 4,5,5,5; bnd=1 on each cycle after out first reaches 5.
- Load load_val=7, which exceeds MAX_VAL: out = 5, bnd = 0. Assert load and en together with load_val=3 while out=5, up=1: out = 3, bnd = 0.
- Reset at out=3 with en=1 and load=1 asserted together: out = 0 and bnd = 0 on the next cycle. en=0 for 4 cycles holds out.
- WIDTH=8 defaults, up from 254: out = 254, 255, 0; tc=1 at 255; bnd pulses after the wrap.
